// File: rtl/sd_sector_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_pkg
// Brief    : Shared constants, loader state encoding and an address helper
//            for the SD sector boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package sd_pkg;

  localparam int SD_SECTOR_BYTES     = 512;
  localparam int SD_SECTOR_SHIFT     = 9;
  localparam int SD_WORDS_PER_SECTOR = 128;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    ISSUE      = 3'd2,
    RECEIVE    = 3'd3,
    NEXT       = 3'd4,
    DONE       = 3'd5
  } loader_state_e;

  // Byte address of the first byte of a sector.
  function automatic logic [31:0] sector_byte_addr(input logic [31:0] sector);
    return sector << SD_SECTOR_SHIFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_sector_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_sector_loader_if
// Brief    : SD byte-read bus plus memory word-write port. The loader is the
//            master; the SD controller / memory side is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface sd_sector_loader_if #(
  parameter int MEM_ADDR_WIDTH = 16
);

  logic                      sd_ready;
  logic                      sd_rd;
  logic [31:0]               sd_address;
  logic [7:0]                sd_dout;
  logic                      sd_byte_available;
  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]               mem_wdata;

  modport master (
    input  sd_ready, sd_dout, sd_byte_available,
    output sd_rd, sd_address, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output sd_ready, sd_dout, sd_byte_available,
    input  sd_rd, sd_address, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/sd_sector_loader_packer.sv
`default_nettype none
// ============================================================================
// Module   : sd_byte_packer
// Brief    : Rising-edge byte strobe detection and big-endian packing of four
//            bytes into a 32-bit word with a registered word-valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module sd_byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        byte_strobe,
  input  logic [7:0]  byte_in,
  output logic        byte_accept,
  output logic        word_valid,
  output logic [31:0] word
);

  logic        strobe_q,     strobe_d;
  logic [1:0]  lane_q,       lane_d;
  logic [23:0] shift_q,      shift_d;
  logic [31:0] word_q,       word_d;
  logic        word_valid_q, word_valid_d;

  // Edge detect and word assembly; first byte of a group lands in the MSB.
  always_comb begin
    strobe_d     = byte_strobe;
    lane_d       = lane_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    byte_accept  = enable & byte_strobe & ~strobe_q;
    if (clear) begin
      lane_d  = 2'd0;
      shift_d = '0;
    end else if (byte_accept) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
      if (lane_q == 2'd3) begin
        word_d       = {shift_q, byte_in};
        word_valid_d = 1'b1;
      end
    end
  end

  // Packer state registers; strobe history always tracks the input level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strobe_q     <= 1'b0;
      lane_q       <= 2'd0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      strobe_q     <= strobe_d;
      lane_q       <= lane_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule
`default_nettype wire

// File: rtl/sd_sector_loader.sv
`default_nettype none
// ============================================================================
// Module   : sd_sector_loader
// Brief    : Boot loader. Reads SECTOR_COUNT contiguous 512-byte sectors from
//            the SD controller starting at START_SECTOR and writes them as
//            big-endian 32-bit words to memory from word address 0.
//            Optional macro SD_TIMEOUT_EN adds an idle-cycle watchdog that
//            aborts the load and raises a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module sd_sector_loader
  import sd_pkg::*;
#(
  parameter int START_SECTOR   = 0,
  parameter int SECTOR_COUNT   = 8,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  sd_sector_loader_if.master  bus
);

  localparam logic [8:0] LAST_BYTE = 9'(SD_SECTOR_BYTES - 1);

  loader_state_e             state_q,      state_d;
  logic [15:0]               sector_cnt_q, sector_cnt_d;
  logic [8:0]                byte_cnt_q,   byte_cnt_d;
  logic [31:0]               sd_address_q, sd_address_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;

  logic        start_accept;
  logic        byte_accept;
  logic        timeout;
  logic        last_sector;
  logic        word_valid;
  logic [31:0] word;

  sd_byte_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (start_accept),
    .enable      (state_q == RECEIVE),
    .byte_strobe (bus.sd_byte_available),
    .byte_in     (bus.sd_dout),
    .byte_accept (byte_accept),
    .word_valid  (word_valid),
    .word        (word)
  );

  assign last_sector = ({1'b0, sector_cnt_q} + 17'd1) == 17'(SECTOR_COUNT);

`ifdef SD_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        error_q,   error_d;

  // Watchdog: counts cycles without progress while waiting on the controller.
  always_comb begin
    tmo_cnt_d = '0;
    timeout   = 1'b0;
    error_d   = error_q;
    if ((state_q == WAIT_READY && !bus.sd_ready) ||
        (state_q == RECEIVE && !byte_accept)) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
      if (tmo_cnt_d == 32'(TIMEOUT_CYCLES)) begin
        timeout   = 1'b1;
        tmo_cnt_d = '0;
      end
    end
    if (start_accept) begin
      error_d = 1'b0;
    end else if (timeout) begin
      error_d = 1'b1;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      error_q   <= error_d;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  // The watchdog limit has no effect in this build; error is constant 0.
  assign error   = (TIMEOUT_CYCLES < 0);
`endif

  // Load sequencing, sector/byte counting and address generation.
  always_comb begin
    state_d      = state_q;
    sector_cnt_d = sector_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    sd_address_d = sd_address_q;
    mem_addr_d   = mem_addr_q;
    start_accept = 1'b0;
    if (word_valid) begin
      mem_addr_d = mem_addr_q + MEM_ADDR_WIDTH'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = WAIT_READY;
          sector_cnt_d = '0;
          byte_cnt_d   = '0;
          mem_addr_d   = '0;
          sd_address_d = sector_byte_addr(32'(START_SECTOR));
        end
      end
      WAIT_READY: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (bus.sd_ready) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RECEIVE;
      end
      RECEIVE: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (byte_accept) begin
          byte_cnt_d = byte_cnt_q + 9'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        if (last_sector) begin
          state_d = DONE;
        end else begin
          sector_cnt_d = sector_cnt_q + 16'd1;
          sd_address_d = sector_byte_addr(32'(START_SECTOR) + 32'(sector_cnt_q) + 32'd1);
          state_d      = WAIT_READY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Loader state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sector_cnt_q <= '0;
      byte_cnt_q   <= '0;
      sd_address_q <= '0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      sector_cnt_q <= sector_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      sd_address_q <= sd_address_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign busy           = (state_q == WAIT_READY) || (state_q == ISSUE) ||
                          (state_q == RECEIVE)    || (state_q == NEXT);
  assign done           = (state_q == DONE);
  assign bus.sd_rd      = (state_q == ISSUE);
  assign bus.sd_address = sd_address_q;
  assign bus.mem_we     = word_valid;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = word;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_sector_loader
// Brief    : Scoreboard bench for sd_sector_loader with a randomized SD byte
//            source and a byte-stream reference model of the memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_sector_loader;
  import sd_pkg::*;

  localparam int START = 3;
  localparam int NSEC  = 2;
  localparam int AW    = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error;

  sd_sector_loader_if #(.MEM_ADDR_WIDTH(AW)) bus ();

  sd_sector_loader #(
    .START_SECTOR   (START),
    .SECTOR_COUNT   (NSEC),
    .MEM_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .bus     (bus)
  );

  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  int exp_done  = 0;
  int done_seen = 0;
  int wr_seen   = 0;
  wr_t         mon_wr;
  logic [31:0] mon_rd;
  logic [7:0]  head [8] = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h80, 8'h40, 8'h00, 8'h0F};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT produced an event with nothing expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT event against the scoreboard queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_we) begin
        wr_seen++;
        if (exp_wr.size() == 0) unexpected("mem_write");
        else begin
          mon_wr = exp_wr.pop_front();
          check("mem_addr", 64'(bus.mem_addr), 64'(mon_wr.addr));
          check("mem_wdata", 64'(bus.mem_wdata), 64'(mon_wr.data));
        end
      end
      if (bus.sd_rd) begin
        if (exp_rd.size() == 0) unexpected("sd_rd");
        else begin
          mon_rd = exp_rd.pop_front();
          check("sd_address", 64'(bus.sd_address), 64'(mon_rd));
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done == 0) unexpected("done");
        else begin
          exp_done--;
          check("busy_at_done", 64'(busy), 64'(0));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    64'(busy), 0);
    check({tag, "_done"},    64'(done), 0);
    check({tag, "_error"},   64'(error), 0);
    check({tag, "_sd_rd"},   64'(bus.sd_rd), 0);
    check({tag, "_sd_addr"}, 64'(bus.sd_address), 0);
    check({tag, "_mem_we"},  64'(bus.mem_we), 0);
    check({tag, "_mem_addr"},64'(bus.mem_addr), 0);
    check({tag, "_wdata"},   64'(bus.mem_wdata), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    bus.sd_dout = b;
    bus.sd_byte_available = 1'b1;
    repeat (hold) tick();
    bus.sd_byte_available = 1'b0;
    bus.sd_dout = 8'($urandom);
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic wait_rd(output bit ok);
    int t;
    bus.sd_ready = 1'b1;
    t = 0;
    while (!bus.sd_rd && t < 40) begin
      tick();
      t++;
    end
    bus.sd_ready = 1'b0;
    ok = bus.sd_rd;
    check("sd_rd_seen", 64'(bus.sd_rd), 1);
    tick();
  endtask

  // One load; the model is the memory image implied by the byte stream.
  task automatic run_load(input int hold, input int abort_at, input bit use_head, input bit poke_start);
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] waddr;
    int nb, t, done_before, wr_before;
    bit ok;
    waddr = '0;
    word  = '0;
    nb    = 0;
    done_before = done_seen;
    wr_before   = wr_seen;
    if (abort_at < 0) exp_done++;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 1);
    for (int s = 0; s < NSEC; s++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.sd_byte_available = 1'b1;
        bus.sd_dout = 8'($urandom);
        tick();
        bus.sd_byte_available = 1'b0;
        tick();
      end
      exp_rd.push_back(32'((START + s) * SD_SECTOR_BYTES));
      wait_rd(ok);
      if (!ok) return;
      for (int i = 0; i < SD_SECTOR_BYTES; i++) begin
        if (abort_at >= 0 && nb == abort_at) begin
          repeat (3) tick();
          check("writes_left_abort", 64'(exp_wr.size()), 0);
          reset_n = 1'b0;
          tick();
          check_all_zero("mid_reset");
          reset_n = 1'b1;
          exp_wr.delete();
          exp_rd.delete();
          tick();
          return;
        end
        b = (use_head && nb < 8) ? head[nb] : 8'($urandom);
        word = {word[23:0], b};
        if (nb % 4 == 3) begin
          exp_wr.push_back({waddr, word});
          waddr++;
        end
        send_byte(b, hold);
        nb++;
        if (poke_start && nb == 100) begin
          start = 1'b1;
          tick();
          start = 1'b0;
        end
      end
    end
    t = 0;
    while (done_seen == done_before && t < 20) begin
      tick();
      t++;
    end
    tick();
    check("done_count", 64'(done_seen - done_before), 1);
    check("write_count", 64'(wr_seen - wr_before), 64'(NSEC * SD_WORDS_PER_SECTOR));
    check("busy_after_done", 64'(busy), 0);
    check("writes_left", 64'(exp_wr.size()), 0);
    check("reads_left", 64'(exp_rd.size()), 0);
  endtask

  initial begin
    bus.sd_ready          = 1'b0;
    bus.sd_dout           = 8'h00;
    bus.sd_byte_available = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();
    run_load(1, -1, 1'b1, 1'b0);
    run_load(3, -1, 1'b1, 1'b0);
    run_load(1, -1, 1'b0, 1'b1);
    run_load(2, 200, 1'b0, 1'b0);
    run_load(1, -1, 1'b1, 1'b0);
`ifdef SD_TIMEOUT_EN
    begin
      int t2, d0;
      bit ok2;
      logic [31:0] w;
      logic [7:0]  bb;
      w  = '0;
      d0 = done_seen;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_rd.push_back(32'(START * SD_SECTOR_BYTES));
      wait_rd(ok2);
      for (int i = 0; i < 10; i++) begin
        bb = 8'($urandom);
        w  = {w[23:0], bb};
        if (i % 4 == 3) exp_wr.push_back({16'(i / 4), w});
        send_byte(bb, 1);
      end
      t2 = 0;
      while (!error && t2 < 101) begin
        tick();
        t2++;
      end
      check("timeout_error", 64'(error), 1);
      check("timeout_busy", 64'(busy), 0);
      check("timeout_no_done", 64'(done_seen - d0), 0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
